// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code sequence encoder: state enum,
// binary-to-Gray conversion and the single-bit-change test used by the self-check.
package gray_pkg;

  localparam int GRAY_W     = 4;
  // Helpers work on a wide word; callers zero-extend and truncate to their width.
  localparam int GRAY_MAX_W = 32;

  typedef enum logic {
    RUN_IDLE = 1'b0,
    WAIT_ACK = 1'b1
  } gray_state_e;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic is_one_hot(input logic [GRAY_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - GRAY_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/gray_seq_encoder_tick_gen.sv
// Step prescaler: counts 0..DIV-1 while en=1 and emits tick on the last count.
// clr restarts the count so a load re-times the following step.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments to avoid ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gray_seq_encoder.sv
// Prescaled up/down counter presented as a registered Gray word with valid/ready.
// Optional GRAY_SELF_CHECK_EN adds a sticky err output flagging multi-bit Gray steps.
module gray_seq_encoder
  import gray_pkg::*;
#(
  parameter int WIDTH       = GRAY_W,
  parameter int CLK_FREQ_HZ = 27_000_000,
  parameter int STEP_HZ     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray_code,
  output logic             gray_valid,
  input  logic             gray_ready,
  output logic             wrap,
  output logic             overrun
`ifdef GRAY_SELF_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int             DIV     = CLK_FREQ_HZ / STEP_HZ;
  localparam logic [WIDTH-1:0] BIN_MAX = '1;

  if (DIV < 1) begin : g_bad_div
    $error("gray_seq_encoder: CLK_FREQ_HZ/STEP_HZ must be >= 1");
  end
  if (WIDTH < 2 || WIDTH > GRAY_MAX_W) begin : g_bad_width
    $error("gray_seq_encoder: WIDTH out of range");
  end

  gray_state_e      state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d, gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             overrun_q, overrun_d;
  logic             pending_q, pending_d;
  logic             pend_up_q, pend_up_d;
  logic             tick, step_en, step_up;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    wrap_d    = 1'b0;
    overrun_d = overrun_q;
    pending_d = pending_q;
    pend_up_d = pend_up_q;
    step_en   = 1'b0;
    step_up   = up_down;

    if (load) begin
      bin_d     = load_bin;
      pending_d = 1'b0;
      state_d   = WAIT_ACK;
    end else begin
      case (state_q)
        RUN_IDLE: begin
          if (tick) begin
            step_en = 1'b1;
            state_d = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (gray_ready && pending_q) begin
            // Deferred step uses the direction sampled on its own tick.
            step_en   = 1'b1;
            step_up   = pend_up_q;
            pending_d = 1'b0;
            if (tick) overrun_d = 1'b1;
          end else if (gray_ready) begin
            if (tick) step_en = 1'b1;
            else      state_d = RUN_IDLE;
          end else if (tick) begin
            if (pending_q) begin
              overrun_d = 1'b1;
            end else begin
              pending_d = 1'b1;
              pend_up_d = up_down;
            end
          end
        end
        default: state_d = RUN_IDLE;
      endcase
    end

    if (step_en) begin
      bin_d  = step_up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
      wrap_d = step_up ? (bin_q == BIN_MAX) : (bin_q == '0);
    end
    gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(bin_d)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN_IDLE;
      bin_q     <= '0;
      gray_q    <= '0;
      wrap_q    <= 1'b0;
      overrun_q <= 1'b0;
      pending_q <= 1'b0;
      pend_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      gray_q    <= gray_d;
      wrap_q    <= wrap_d;
      overrun_q <= overrun_d;
      pending_q <= pending_d;
      pend_up_q <= pend_up_d;
    end
  end

  assign gray_code  = gray_q;
  assign gray_valid = (state_q == WAIT_ACK);
  assign wrap       = wrap_q;
  assign overrun    = overrun_q;

`ifdef GRAY_SELF_CHECK_EN
  // shadow_q keeps the word before the last update; chk_q marks counting updates.
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             chk_q, chk_d, err_q, err_d;

  always_comb begin
    shadow_d = shadow_q;
    chk_d    = step_en && !load;
    err_d    = err_q;
    if (step_en || load) shadow_d = gray_q;
    if (chk_q && !is_one_hot(GRAY_MAX_W'(shadow_q ^ gray_q))) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      chk_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      chk_q    <= chk_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_gray_seq_encoder.sv
// Self-checking bench for gray_seq_encoder (DIV=4, WIDTH=4): directed scenarios
// plus randomized traffic compared cycle by cycle against an integer reference model.
module tb_gray_seq_encoder;

  localparam int W   = 4;
  localparam int DIV = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst, en, up_down, load, gray_ready;
  logic [W-1:0] load_bin, gray_code;
  logic         gray_valid, wrap, overrun;
`ifdef GRAY_SELF_CHECK_EN
  logic         err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_seq_encoder #(.WIDTH(W), .CLK_FREQ_HZ(4), .STEP_HZ(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up_down    (up_down),
    .load       (load),
    .load_bin   (load_bin),
    .gray_code  (gray_code),
    .gray_valid (gray_valid),
    .gray_ready (gray_ready),
    .wrap       (wrap),
    .overrun    (overrun)
`ifdef GRAY_SELF_CHECK_EN
    ,
    .err        (err)
`endif
  );

  // Reference model: plain integers following the behavioural rules.
  int           m_cnt, m_bin;
  logic [W-1:0] m_gray;
  bit           m_valid, m_pend, m_pdir, m_ovr, m_wrap;

  function automatic logic [W-1:0] to_gray(int b);
    logic [W-1:0] v = W'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_bin = 0; m_gray = '0;
    m_valid = 0; m_pend = 0; m_pdir = 0; m_ovr = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit dir);
    m_wrap = dir ? (m_bin == MOD - 1) : (m_bin == 0);
    m_bin  = (m_bin + (dir ? 1 : MOD - 1)) % MOD;
    m_gray = to_gray(m_bin);
  endtask

  task automatic model_edge();
    bit tk = en && (m_cnt == DIV - 1);
    m_wrap = 0;
    if (load) begin
      m_bin = int'(load_bin); m_gray = to_gray(m_bin);
      m_cnt = 0; m_pend = 0; m_valid = 1;
    end else begin
      if (en) m_cnt = (m_cnt + 1) % DIV;
      if (!m_valid) begin
        if (tk) begin model_step(up_down); m_valid = 1; end
      end else if (gray_ready) begin
        if (m_pend) begin
          model_step(m_pdir); m_pend = 0;
          if (tk) m_ovr = 1;
        end else if (tk) model_step(up_down);
        else m_valid = 0;
      end else if (tk) begin
        if (m_pend) m_ovr = 1;
        else begin m_pend = 1; m_pdir = up_down; end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("gray_code", gray_code, m_gray);
    check("gray_valid", gray_valid, m_valid);
    check("wrap", wrap, m_wrap);
    check("overrun", overrun, m_ovr);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin cycle(); n++; end while (!gray_valid && n < budget);
    if (!gray_valid) check("valid_timeout", 0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, b;
    logic [W-1:0] g;
    logic [W-1:0] exp_seq [4];
    exp_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};

    rst = 1; en = 0; up_down = 1; load = 0; load_bin = '0; gray_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gray", gray_code, 0);
    check("rst_valid", gray_valid, 0);
    check("rst_wrap", wrap, 0);
    check("rst_overrun", overrun, 0);
    rst = 0;

    // Free-running up count with immediate accept.
    en = 1; up_down = 1; gray_ready = 1;
    for (int i = 0; i < 4; i++) begin
      wait_valid(8, n);
      check("s1_seq", gray_code, exp_seq[i]);
      check("s1_period", n, DIV);
    end

    // Wrap up from 15 and down from 0.
    load = 1; load_bin = 4'hF;
    cycle();
    load = 0;
    check("s2_load_gray", gray_code, 4'b1000);
    check("s2_load_wrap", wrap, 0);
    wait_valid(8, n);
    check("s2_up_gray", gray_code, 4'b0000);
    check("s2_up_wrap", wrap, 1);
    load = 1; load_bin = 4'h0; up_down = 0;
    cycle();
    load = 0;
    wait_valid(8, n);
    check("s2_dn_gray", gray_code, 4'b1000);
    check("s2_dn_wrap", wrap, 1);

    // Back-pressure: pending then overrun, value held.
    up_down = 1; gray_ready = 0;
    wait_valid(8, n);
    g = gray_code; b = m_bin;
    for (int i = 0; i < 12; i++) begin
      cycle();
      check("s3_hold", gray_code, g);
    end
    check("s3_overrun_set", overrun, 1);
    gray_ready = 1;
    cycle();
    check("s3_pending_applied", gray_code, to_gray(b + 1));
    check("s3_overrun_sticky", overrun, 1);

    // Load coinciding with a tick.
    n = 0;
    while (m_cnt != DIV - 1 && n < 2 * DIV) begin cycle(); n++; end
    check("s4_found_tick", m_cnt, DIV - 1);
    load = 1; load_bin = 4'b0101;
    cycle();
    load = 0;
    check("s4_load_gray", gray_code, 4'b0111);
    check("s4_load_wrap", wrap, 0);
    wait_valid(8, n);
    check("s4_next_delay", n, DIV);
    check("s4_next_gray", gray_code, to_gray(6));

    // Asynchronous reset in the middle of a handshake.
    gray_ready = 0;
    wait_valid(8, n);
    #3;
    rst = 1;
    #1;
    check("s5_async_gray", gray_code, 0);
    check("s5_async_valid", gray_valid, 0);
    check("s5_async_wrap", wrap, 0);
    check("s5_async_overrun", overrun, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0; gray_ready = 1; en = 1; up_down = 1;
    wait_valid(8, n);
    check("s5_first_delay", n, DIV);
    check("s5_first_gray", gray_code, 4'b0001);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en         = ($urandom_range(0, 7) != 0);
      up_down    = 1'($urandom_range(0, 1));
      gray_ready = ($urandom_range(0, 2) != 0);
      load       = ($urandom_range(0, 19) == 0);
      load_bin   = W'($urandom);
      cycle();
    end
    load = 0;

`ifdef GRAY_SELF_CHECK_EN
    en = 1; gray_ready = 1;
    cycle();
    for (int i = 0; i < 40; i++) begin
      up_down = 1'($urandom_range(0, 1));
      wait_valid(8, n);
      cycle();
      check("sc_err_clean", err, 0);
    end
    // Glitch the counter so the next up-step repeats the current word.
    up_down = 1;
    g = gray_code;
    m_bin = (m_bin + MOD - 1) % MOD;
    dut.bin_q = W'(m_bin);
    wait_valid(8, n);
    check("sc_glitch_gray", gray_code, g);
    cycle();
    check("sc_err_set", err, 1);
    repeat (5) cycle();
    check("sc_err_sticky", err, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
